// File: rtl/tcdm_rr_bank_arbiter.sv
// tcdm_rr_bank_arbiter: round-robin N-to-1 TCDM bank arbiter with request hold and single-cycle response routing
module tcdm_rr_bank_arbiter #(
  parameter int NR_MASTER_PORTS = 4,
  parameter int RESP_LAT = 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   test_en_i,
  input  logic [NR_MASTER_PORTS-1:0]             m_req_i,
  input  logic [NR_MASTER_PORTS-1:0][31:0]       m_add_i,
  input  logic [NR_MASTER_PORTS-1:0]             m_wen_i,
  input  logic [NR_MASTER_PORTS-1:0][3:0]        m_be_i,
  input  logic [NR_MASTER_PORTS-1:0][31:0]       m_wdata_i,
  output logic [NR_MASTER_PORTS-1:0]             m_gnt_o,
  output logic [NR_MASTER_PORTS-1:0]             m_r_valid_o,
  output logic [31:0]                            m_r_rdata_o,
  output logic                                   m_r_opc_o,
  output logic                                   s_req_o,
  output logic [31:0]                            s_add_o,
  output logic                                   s_wen_o,
  output logic [3:0]                             s_be_o,
  output logic [31:0]                            s_wdata_o,
  input  logic                                   s_gnt_i,
  input  logic [31:0]                            s_r_rdata_i,
  input  logic                                   s_r_opc_i
);
  localparam int N  = NR_MASTER_PORTS;
  localparam int IW = $clog2(N);
  if (RESP_LAT != 1) begin : g_bad_lat
    $error("tcdm_rr_bank_arbiter: RESP_LAT must be 1");
  end
  if (N < 2 || N > 16) begin : g_bad_n
    $error("tcdm_rr_bank_arbiter: NR_MASTER_PORTS must be 2..16");
  end
  typedef enum logic {ARB, HOLD} state_t;
  state_t        state;
  logic [IW-1:0] rr_ptr, sel_q, sel_rr, sel, rsp_idx_q;
  logic          rsp_vld_q, hs;
  logic          unused_test_en;
  assign unused_test_en = test_en_i;
  // Scan downward so the requester closest to rr_ptr is the last (winning) assignment
  always_comb begin
    sel_rr = rr_ptr;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= N) j -= N;
      if (m_req_i[IW'(j)]) sel_rr = IW'(j);
    end
  end
  assign sel         = state == HOLD ? sel_q : sel_rr;
  assign s_req_o     = state == HOLD ? m_req_i[sel_q] : |m_req_i;
  assign hs          = s_req_o & s_gnt_i & rst_ni;
  assign m_gnt_o     = {{(N-1){1'b0}}, hs} << sel;
  assign m_r_valid_o = {{(N-1){1'b0}}, rsp_vld_q} << rsp_idx_q;
  assign s_add_o     = m_add_i[sel];
  assign s_wen_o     = m_wen_i[sel];
  assign s_be_o      = m_be_i[sel];
  assign s_wdata_o   = m_wdata_i[sel];
  assign m_r_rdata_o = s_r_rdata_i;
  assign m_r_opc_o   = s_r_opc_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ARB;
      rr_ptr    <= '0;
      sel_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_idx_q <= '0;
    end else begin
      rsp_vld_q <= hs;
      if (hs) begin
        rsp_idx_q <= sel;
        rr_ptr    <= sel == IW'(N - 1) ? '0 : sel + 1'b1;
      end
      if (state == ARB) begin
        if (s_req_o && !s_gnt_i) begin
          state <= HOLD;
          sel_q <= sel;
        end
      end else if (!m_req_i[sel_q] || s_gnt_i) begin
        state <= ARB;
      end
    end
  end
endmodule

// File: tb/tb_tcdm_rr_bank_arbiter.sv
// tb_tcdm_rr_bank_arbiter: directed vectors plus a per-cycle reference model of the round-robin arbiter
module tb_tcdm_rr_bank_arbiter;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       req = '0;
  logic [3:0][31:0] madd, mwdata;
  logic [3:0]       mwen;
  logic [3:0][3:0]  mbe;
  logic [3:0]       gnt, vld;
  logic [31:0]      rdata_o, s_add, s_wdata, rdata = '0;
  logic             opc_o, s_req, s_wen, sgnt = 1'b0, opc = 1'b0;
  logic [3:0]       s_be;
  int               checks = 0, errors = 0;
  bit               run = 1'b0;
  int               ptr = 0, lock_m = 0, pend = -1, m;
  bit               locked = 1'b0, esreq, ehs;

  always #5 clk = ~clk;

  tcdm_rr_bank_arbiter #(.NR_MASTER_PORTS(4), .RESP_LAT(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0),
    .m_req_i(req), .m_add_i(madd), .m_wen_i(mwen), .m_be_i(mbe), .m_wdata_i(mwdata),
    .m_gnt_o(gnt), .m_r_valid_o(vld), .m_r_rdata_o(rdata_o), .m_r_opc_o(opc_o),
    .s_req_o(s_req), .s_add_o(s_add), .s_wen_o(s_wen), .s_be_o(s_be), .s_wdata_o(s_wdata),
    .s_gnt_i(sgnt), .s_r_rdata_i(rdata), .s_r_opc_i(opc)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q, input logic g);
    @(posedge clk);
    #1;
    rst_n = r;
    req = q;
    sgnt = g;
    rdata = $urandom;
    opc = 1'($urandom);
    @(negedge clk);
  endtask

  // Reference: first requester at or after ptr wins unless locked; a grant answers next cycle
  always @(negedge clk) if (run) begin
    if (!rst_n) begin
      chk("m_sreq_rst", 32'(s_req), 32'(|req));
      chk("m_gnt_rst", 32'(gnt), 0);
      chk("m_vld_rst", 32'(vld), 0);
      ptr = 0;
      locked = 1'b0;
      pend = -1;
    end else begin
      m = -1;
      if (locked) m = lock_m;
      else for (int k = 0; k < 4; k++) if (m < 0 && req[2'((ptr + k) % 4)]) m = (ptr + k) % 4;
      esreq = locked ? req[2'(lock_m)] : |req;
      ehs = esreq && sgnt;
      chk("m_gnt", 32'(gnt), ehs ? 32'(1) << m : 0);
      chk("m_vld", 32'(vld), pend >= 0 ? 32'(1) << pend : 0);
      chk("m_sreq", 32'(s_req), 32'(esreq));
      if (esreq) begin
        chk("m_sadd", s_add, madd[2'(m)]);
        chk("m_swen", 32'(s_wen), 32'(mwen[2'(m)]));
        chk("m_sbe", 32'(s_be), 32'(mbe[2'(m)]));
        chk("m_swdata", s_wdata, mwdata[2'(m)]);
      end
      chk("m_rdata", rdata_o, rdata);
      chk("m_opc", 32'(opc_o), 32'(opc));
      if (locked) locked = req[2'(lock_m)] && !sgnt;
      else begin
        locked = esreq && !sgnt;
        lock_m = m;
      end
      pend = ehs ? m : -1;
      if (ehs) ptr = (m + 1) % 4;
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      madd[i] = 32'h1000_0000 | (i << 4);
      mwdata[i] = 32'hA000_0000 + i;
      mwen[i] = i[0];
      mbe[i] = 4'h1 << i;
    end
    run = 1'b1;
    step(0, 4'b0000, 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_vld", 32'(vld), 0);
    step(0, 4'b1010, 1);
    chk("rst_sreq", 32'(s_req), 1);
    chk("rst_gnt_req", 32'(gnt), 0);
    for (int k = 0; k < 8; k++) begin
      step(1, 4'hF, 1);
      chk("rr_gnt", 32'(gnt), 32'(1) << (k % 4));
      if (k > 0) chk("rr_vld", 32'(vld), 32'(1) << ((k - 1) % 4));
    end
    step(1, 4'b0000, 0);
    chk("rr_vld_last", 32'(vld), 32'h8);
    step(1, 4'b0110, 0);
    chk("hold_add0", s_add, 32'h1000_0010);
    chk("hold_gnt0", 32'(gnt), 0);
    step(1, 4'b0110, 0);
    chk("hold_add1", s_add, 32'h1000_0010);
    step(1, 4'b1110, 0);
    chk("hold_add2", s_add, 32'h1000_0010);
    step(1, 4'b1110, 1);
    chk("hold_gnt3", 32'(gnt), 32'h2);
    step(1, 4'b0000, 0);
    chk("hold_vld4", 32'(vld), 32'h2);
    #1;
    madd[2] = 32'h1C00_0010;
    mwen[2] = 1'b0;
    mbe[2] = 4'hF;
    step(1, 4'b0100, 1);
    chk("wr_gnt", 32'(gnt), 32'h4);
    chk("wr_add", s_add, 32'h1C00_0010);
    chk("wr_wen", 32'(s_wen), 0);
    chk("wr_be", 32'(s_be), 32'hF);
    step(1, 4'b0000, 0);
    chk("wr_vld", 32'(vld), 32'h4);
    chk("wr_rdata", rdata_o, rdata);
    for (int k = 0; k < 4; k++) begin
      step(1, 4'b0001, 1);
      chk("single_gnt", 32'(gnt), 32'h1);
      if (k > 0) chk("single_vld", 32'(vld), 32'h1);
    end
    step(1, 4'b1100, 1);
    chk("prerst_gnt", 32'(gnt), 32'h4);
    step(0, 4'b1100, 1);
    chk("midrst_vld", 32'(vld), 0);
    chk("midrst_gnt", 32'(gnt), 0);
    step(1, 4'b1010, 1);
    chk("postrst_vld", 32'(vld), 0);
    chk("postrst_gnt", 32'(gnt), 32'h2);
    step(1, 4'b0000, 0);
    chk("postrst_vld1", 32'(vld), 32'h2);
    step(1, 4'b0011, 0);
    chk("drop_gnt0", 32'(gnt), 0);
    chk("drop_add0", s_add, 32'h1000_0000);
    step(1, 4'b0010, 1);
    chk("drop_sreq", 32'(s_req), 0);
    chk("drop_gnt1", 32'(gnt), 0);
    step(1, 4'b0010, 1);
    chk("drop_gnt2", 32'(gnt), 32'h2);
    step(1, 4'b0000, 0);
    chk("drop_vld", 32'(vld), 32'h2);
    for (int k = 0; k < 60; k++) step(1, 4'($urandom), 1'($urandom));
    step(1, 4'b0000, 0);
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
